// File: rtl/cpu_fetch_pkg.sv
// Shared types and defaults for the fetch front end and its instruction queue.
package cpu_fetch_pkg;

  localparam int unsigned XLEN             = 32;
  localparam int unsigned IQ_DEPTH_DEFAULT = 8;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h1ECE_B000;

  typedef logic [XLEN-1:0] instr_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/instr_queue.sv
// Circular instruction FIFO; head is presented from registered state with no bypass.
// IQ_ASSERT_EN adds simulation checks for push-while-full and pop-while-empty.
module instr_queue
  import cpu_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = IQ_DEPTH_DEFAULT
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   i_push,
  input  logic   i_pop,
  input  instr_t i_data,
  output instr_t o_data,
  output logic   o_empty,
  output logic   o_full
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned PTR_W = AW + 1;

  instr_t           r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic             w_empty;
  logic             w_full;
  logic             w_do_push;
  logic             w_do_pop;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign w_empty   = (r_head == r_tail);
  assign w_full    = (r_head[AW-1:0] == r_tail[AW-1:0]) && (r_head[AW] != r_tail[AW]);
  assign w_do_push = i_push && !w_full;
  assign w_do_pop  = i_pop && !w_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (w_do_push) r_tail <= r_tail + PTR_W'(1);
      if (w_do_pop)  r_head <= r_head + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_do_push) r_mem[r_tail[AW-1:0]] <= i_data;
  end

  assign o_data  = w_empty ? '0 : r_mem[r_head[AW-1:0]];
  assign o_empty = w_empty;
  assign o_full  = w_full;

`ifdef IQ_ASSERT_EN
  a_push_full: assert property (@(posedge clk) disable iff (rst) !(i_push && w_full))
    else $error("instr_queue: push while full");
  a_pop_empty: assert property (@(posedge clk) disable iff (rst) !(i_pop && w_empty))
    else $error("instr_queue: pop while empty");
`endif

endmodule

// File: rtl/cpu_fetch_iqueue.sv
// Sequential fetch FSM feeding an instruction queue; data port tied off.
// IQ_ASSERT_EN enables simulation-only protocol assertions.
module cpu_fetch_iqueue
  import cpu_fetch_pkg::*;
#(
  parameter int unsigned SUPERSCALAR = 1,
  parameter int unsigned IQ_DEPTH    = IQ_DEPTH_DEFAULT,
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  output logic [3:0]  imem_rmask,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_rmask,
  output logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_resp,
  output instr_t      instr           [SUPERSCALAR],
  output logic        instr_valid_out [SUPERSCALAR]
);

  fetch_state_t r_state;
  fetch_state_t w_state_next;
  logic [31:0]  r_pc;
  logic [31:0]  w_pc_next;
  logic [3:0]   w_rmask;
  logic         w_push;
  logic         w_pop;
  instr_t       w_q_data;
  logic         w_q_empty;
  logic         w_q_full;
  logic         w_unused;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
    end
  end

  // One request in flight; the strobe lives only in the IDLE cycle that issues it.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_rmask      = 4'h0;
    w_push       = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_q_full) begin
          w_rmask      = 4'hF;
          w_state_next = WAIT;
        end
      end
      WAIT: begin
        if (imem_resp) begin
          w_push       = 1'b1;
          w_pc_next    = r_pc + 32'd4;
          w_state_next = IDLE;
        end
      end
    endcase
  end

  assign imem_addr  = r_pc;
  assign imem_rmask = rst ? 4'h0 : w_rmask;

  // Decode stub is always ready.
  assign w_pop = !w_q_empty;

  instr_queue #(
    .DEPTH (IQ_DEPTH)
  ) u_iq (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (imem_rdata),
    .o_data  (w_q_data),
    .o_empty (w_q_empty),
    .o_full  (w_q_full)
  );

  always_comb begin
    for (int i = 0; i < int'(SUPERSCALAR); i++) begin
      instr[i]           = (i == 0) ? w_q_data : '0;
      instr_valid_out[i] = (i == 0) ? !w_q_empty : 1'b0;
    end
  end

  assign dmem_addr  = 32'h0;
  assign dmem_rmask = 4'h0;
  assign dmem_wmask = 4'h0;
  assign dmem_wdata = 32'h0;
  assign w_unused   = ^{dmem_rdata, dmem_resp};

`ifdef IQ_ASSERT_EN
  logic r_rst_d;

  always_ff @(posedge clk) r_rst_d <= rst;

  a_rmask_pulse: assert property (@(posedge clk) disable iff (rst)
    (imem_rmask != 4'h0) |=> (imem_rmask == 4'h0))
    else $error("cpu_fetch_iqueue: imem_rmask held for 2 cycles");
  a_resp_idle: assert property (@(posedge clk) disable iff (rst)
    (imem_resp && (r_state == IDLE)) |-> r_rst_d)
    else $error("cpu_fetch_iqueue: imem_resp while IDLE");
`endif

endmodule

// File: tb/tb_cpu_fetch_iqueue.sv
// Directed bench for cpu_fetch_iqueue: reset, back-to-back fetch, slow memory, reset during WAIT.
module tb_cpu_fetch_iqueue;

  localparam logic [31:0] RPC = 32'h1ECE_B000;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_rmask;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_rdata;
  logic [31:0] dmem_wdata;
  logic        dmem_resp;
  logic [31:0] instr           [1];
  logic        instr_valid_out [1];

  int total;
  int bad;

  cpu_fetch_iqueue #(
    .SUPERSCALAR (1),
    .IQ_DEPTH    (8),
    .RESET_PC    (RPC)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_addr       (imem_addr),
    .imem_rmask      (imem_rmask),
    .imem_rdata      (imem_rdata),
    .imem_resp       (imem_resp),
    .dmem_addr       (dmem_addr),
    .dmem_rmask      (dmem_rmask),
    .dmem_wmask      (dmem_wmask),
    .dmem_rdata      (dmem_rdata),
    .dmem_wdata      (dmem_wdata),
    .dmem_resp       (dmem_resp),
    .instr           (instr),
    .instr_valid_out (instr_valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_dmem();
    chk("dmem_out", {dmem_addr ^ dmem_wdata, 24'h0, dmem_rmask, dmem_wmask} | dmem_addr, 32'h0);
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] d;
    total      = 0;
    bad        = 0;
    rst        = 1'b1;
    imem_resp  = 1'b0;
    imem_rdata = 32'h0;
    dmem_rdata = 32'h0;
    dmem_resp  = 1'b0;

    // Held in reset for 4 cycles.
    for (int i = 0; i < 4; i++) begin
      cyc();
      #1;
      chk("rst_valid", 32'(instr_valid_out[0]), 32'h0);
      chk("rst_rmask", 32'(imem_rmask), 32'h0);
      chk("rst_addr", imem_addr, RPC);
      chk("rst_instr", instr[0], 32'h0);
    end

    // First cycle after release issues the first fetch.
    cyc();
    rst = 1'b0;
    #1;
    chk("first_rmask", 32'(imem_rmask), 32'hF);
    chk("first_addr", imem_addr, RPC);
    chk_dmem();

    cyc();
    imem_resp  = 1'b1;
    imem_rdata = 32'h0040_0093;
    #1;
    chk("wait_rmask", 32'(imem_rmask), 32'h0);
    chk("wait_valid", 32'(instr_valid_out[0]), 32'h0);

    cyc();
    imem_resp = 1'b0;
    #1;
    chk("w0_valid", 32'(instr_valid_out[0]), 32'h1);
    chk("w0_instr", instr[0], 32'h0040_0093);
    chk("w0_rmask", 32'(imem_rmask), 32'hF);
    chk("w0_addr", imem_addr, RPC + 32'd4);

    cyc();
    #1;
    chk("w0_popped", 32'(instr_valid_out[0]), 32'h0);
    chk("w0_popped_instr", instr[0], 32'h0);

    // Ten back-to-back words with a 1-cycle memory.
    for (int i = 0; i < 10; i++) begin
      d          = 32'h0040_0093 + 32'(i);
      imem_resp  = 1'b1;
      imem_rdata = d;
      #1;
      chk("seq_wait_rmask", 32'(imem_rmask), 32'h0);
      cyc();
      imem_resp = 1'b0;
      #1;
      chk("seq_valid", 32'(instr_valid_out[0]), 32'h1);
      chk("seq_instr", instr[0], d);
      chk("seq_rmask", 32'(imem_rmask), 32'hF);
      chk("seq_addr", imem_addr, RPC + 32'(4 * (i + 2)));
      cyc();
      #1;
      chk("seq_one_cycle", 32'(instr_valid_out[0]), 32'h0);
    end
    chk_dmem();

    // Slow memory: response 10 cycles late.
    for (int i = 0; i < 10; i++) begin
      chk("slow_rmask", 32'(imem_rmask), 32'h0);
      chk("slow_pc_held", imem_addr, RPC + 32'h2C);
      chk("slow_valid", 32'(instr_valid_out[0]), 32'h0);
      cyc();
      #1;
    end
    imem_resp  = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    cyc();
    imem_resp = 1'b0;
    #1;
    chk("slow_valid_push", 32'(instr_valid_out[0]), 32'h1);
    chk("slow_instr", instr[0], 32'hDEAD_BEEF);
    chk("slow_next_addr", imem_addr, RPC + 32'h30);
    chk("slow_next_rmask", 32'(imem_rmask), 32'hF);
    cyc();
    #1;
    chk("slow_single_push", 32'(instr_valid_out[0]), 32'h0);

    // Reset while in WAIT, then a stale response in the first IDLE cycle.
    rst = 1'b1;
    #1;
    chk("rst_in_wait_rmask", 32'(imem_rmask), 32'h0);
    cyc();
    rst        = 1'b0;
    imem_resp  = 1'b1;
    imem_rdata = 32'hBAD0_BAD0;
    #1;
    chk("stale_rmask", 32'(imem_rmask), 32'hF);
    chk("stale_addr", imem_addr, RPC);
    chk("stale_valid", 32'(instr_valid_out[0]), 32'h0);
    cyc();
    imem_resp = 1'b0;
    #1;
    chk("stale_ignored", 32'(instr_valid_out[0]), 32'h0);
    chk("stale_instr", instr[0], 32'h0);
    chk("stale_wait_rmask", 32'(imem_rmask), 32'h0);
    imem_resp  = 1'b1;
    imem_rdata = 32'h1234_5678;
    cyc();
    imem_resp = 1'b0;
    #1;
    chk("post_rst_valid", 32'(instr_valid_out[0]), 32'h1);
    chk("post_rst_instr", instr[0], 32'h1234_5678);
    chk("post_rst_addr", imem_addr, RPC + 32'd4);
    chk_dmem();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
